crc_rx_stream: RTL and testbench

//  Byte-serial receive-side CRC-32 checker with store-and-forward buffering. Sits between the line-side

---
 rtl/udp_crc_pkg.sv | 29 ++
 rtl/rx_frame_buffer.sv | 27 ++
 rtl/crc_rx_stream.sv | 163 ++++++++++++++++
 tb/tb_crc_rx_stream.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_crc_pkg.sv
// Shared CRC-32 definitions for the UDP transmit and receive paths.
// The polynomial is passed in so both paths can be parameterised alike.
package udp_crc_pkg;

  localparam logic [31:0] CRC_POLY_DEFAULT = 32'h973AFB51;
  localparam logic [31:0] CRC_INIT_DEFAULT = 32'h00000000;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StCheck,
    StSend
  } rx_state_e;

  // MSB-first, non-reflected update of crc with one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data,
                                             input logic [31:0] poly);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_frame_buffer.sv
// Simple dual-port frame buffer: synchronous write, registered read.
// Contents are not reset; readers gate the output with their own valid.
module rx_frame_buffer #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [Depth];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/crc_rx_stream.sv
// Receive-side CRC-32 checker with store-and-forward buffering.
// Good frames are forwarded without their 4 CRC bytes; bad frames vanish.
module crc_rx_stream
  import udp_crc_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 64,
  parameter logic [31:0] CRC_POLY  = CRC_POLY_DEFAULT,
  parameter logic [31:0] CRC_INIT  = CRC_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] udp_rx,
  input  logic       udp_rx_valid,
  input  logic       udp_rx_first,
  input  logic       udp_rx_last,
  output logic [7:0] to_udp,
  output logic       to_udp_valid,
  output logic       to_udp_first,
  output logic       to_udp_last,
  output logic       crc_valid,
  output logic       crc_check,
  output logic       rx_busy_drop
);

  localparam int unsigned Aw = $clog2(MAX_BYTES);
  localparam int unsigned Pw = Aw + 1;

  rx_state_e   state_q, state_d;
  logic [Pw-1:0] wr_ptr_q, wr_ptr_d;
  logic [Pw-1:0] rd_ptr_q, rd_ptr_d;
  logic [Pw-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   tail_q, tail_d;
  logic [2:0]    tail_cnt_q, tail_cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic          crc_valid_q, crc_valid_d;
  logic          crc_check_q, crc_check_d;

  logic          start, take;
  logic          we;
  logic [Aw-1:0] waddr, raddr;
  logic [7:0]    rdata;

  rx_frame_buffer #(
    .Depth (MAX_BYTES)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (udp_rx),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    tail_d       = tail_q;
    tail_cnt_d   = tail_cnt_q;
    crc_d        = crc_q;
    crc_valid_d  = 1'b0;
    crc_check_d  = 1'b0;
    we           = 1'b0;
    waddr        = wr_ptr_q[Aw-1:0];
    raddr        = '0;
    to_udp       = 8'h00;
    to_udp_valid = 1'b0;
    to_udp_first = 1'b0;
    to_udp_last  = 1'b0;
    rx_busy_drop = 1'b0;

    start = udp_rx_valid & udp_rx_first & ((state_q == StIdle) | (state_q == StRecv));
    take  = udp_rx_valid & ~udp_rx_first & (state_q == StRecv);

    if (start) begin
      we         = 1'b1;
      waddr      = '0;
      wr_ptr_d   = Pw'(1);
      ovf_d      = 1'b0;
      tail_d     = {24'h0, udp_rx};
      tail_cnt_d = 3'd1;
      crc_d      = CRC_INIT;
      state_d    = StRecv;
    end else if (take) begin
      if (wr_ptr_q == Pw'(MAX_BYTES)) begin
        ovf_d = 1'b1;
      end else begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      tail_d = {tail_q[23:0], udp_rx};
      // Bytes only reach the CRC once they leave the tail, so the CRC never sees the trailer.
      if (tail_cnt_q == 3'd4) begin
        crc_d = crc32_byte(crc_q, tail_q[31:24], CRC_POLY);
      end else begin
        tail_cnt_d = tail_cnt_q + 3'd1;
      end
    end

    // Verdict is computed from next-state values so it is registered one cycle after the last byte.
    if ((start | take) & udp_rx_last) begin
      state_d     = StCheck;
      len_d       = wr_ptr_d;
      crc_valid_d = 1'b1;
      crc_check_d = (wr_ptr_d >= Pw'(4)) & ~ovf_d & (tail_d == ~crc_d);
    end

    case (state_q)
      StCheck: begin
        rx_busy_drop = udp_rx_valid;
        raddr        = '0;
        rd_ptr_d     = '0;
        state_d      = (crc_check_q && (len_q > Pw'(4))) ? StSend : StIdle;
      end
      StSend: begin
        rx_busy_drop = udp_rx_valid;
        to_udp_valid = 1'b1;
        to_udp       = rdata;
        to_udp_first = (rd_ptr_q == '0);
        raddr        = Aw'(rd_ptr_q + 1'b1);
        rd_ptr_d     = rd_ptr_q + 1'b1;
        if (rd_ptr_q == len_q - Pw'(5)) begin
          to_udp_last = 1'b1;
          state_d     = StIdle;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      tail_q      <= '0;
      tail_cnt_q  <= '0;
      crc_q       <= '0;
      crc_valid_q <= 1'b0;
      crc_check_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      tail_q      <= tail_d;
      tail_cnt_q  <= tail_cnt_d;
      crc_q       <= crc_d;
      crc_valid_q <= crc_valid_d;
      crc_check_q <= crc_check_d;
    end
  end

  assign crc_valid = crc_valid_q;
  assign crc_check = crc_check_q;

endmodule

// File: tb/tb_crc_rx_stream.sv
// Randomised and directed bench for crc_rx_stream against a frame-level reference model.
module tb_crc_rx_stream;

  localparam int unsigned MaxBytes = 64;
  localparam logic [31:0] Poly     = 32'h973AFB51;
  localparam logic [31:0] Init     = 32'h00000000;

  logic       clk, rst_n;
  logic [7:0] udp_rx;
  logic       udp_rx_valid, udp_rx_first, udp_rx_last;
  logic [7:0] to_udp;
  logic       to_udp_valid, to_udp_first, to_udp_last;
  logic       crc_valid, crc_check, rx_busy_drop;

  crc_rx_stream #(
    .MAX_BYTES (MaxBytes),
    .CRC_POLY  (Poly),
    .CRC_INIT  (Init)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .udp_rx       (udp_rx),
    .udp_rx_valid (udp_rx_valid),
    .udp_rx_first (udp_rx_first),
    .udp_rx_last  (udp_rx_last),
    .to_udp       (to_udp),
    .to_udp_valid (to_udp_valid),
    .to_udp_first (to_udp_first),
    .to_udp_last  (to_udp_last),
    .crc_valid    (crc_valid),
    .crc_check    (crc_check),
    .rx_busy_drop (rx_busy_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Observed traffic, collected mid-cycle.
  int         v_cyc[$];
  bit         v_val[$];
  logic [7:0] o_dat[$];
  bit         o_first[$];
  bit         o_last[$];
  int         o_cyc[$];
  int         drops;

  always @(negedge clk) begin
    if (rst_n) begin
      if (crc_valid) begin
        v_cyc.push_back(cyc);
        v_val.push_back(crc_check);
      end
      if (to_udp_valid) begin
        o_dat.push_back(to_udp);
        o_first.push_back(to_udp_first);
        o_last.push_back(to_udp_last);
        o_cyc.push_back(cyc);
      end
      if (rx_busy_drop) drops++;
    end
  end

  logic [7:0] frame_q[$];
  int         last_cyc;

  // Whole-byte formulation of the CRC over frame_q[0..n-1].
  function automatic logic [31:0] model_crc(input int n);
    logic [31:0] c;
    c = Init;
    for (int i = 0; i < n; i++) begin
      c = c ^ {frame_q[i], 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ Poly) : (c << 1);
    end
    return c;
  endfunction

  task automatic build_payload(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
  endtask

  task automatic append_crc();
    logic [31:0] c;
    c = ~model_crc(frame_q.size());
    for (int k = 3; k >= 0; k--) frame_q.push_back(c[8*k +: 8]);
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit f, input bit l);
    @(posedge clk);
    #1;
    udp_rx       = b;
    udp_rx_valid = 1'b1;
    udp_rx_first = f;
    udp_rx_last  = l;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    udp_rx_valid = 1'b0;
    udp_rx_first = 1'b0;
    udp_rx_last  = 1'b0;
  endtask

  task automatic clear_mon();
    v_cyc.delete();
    v_val.delete();
    o_dat.delete();
    o_first.delete();
    o_last.delete();
    o_cyc.delete();
    drops = 0;
  endtask

  // Sends frame_q (optionally preceded by an aborted prefix), then checks verdict and output.
  task automatic run_frame(input string tag, input int prefix, input int inject, input bit gaps);
    int          len, n_pay, n_chk;
    bit          exp_pass;
    logic [31:0] tl;
    len      = frame_q.size();
    exp_pass = 1'b0;
    if (len >= 4 && len <= MaxBytes) begin
      tl       = {frame_q[len-4], frame_q[len-3], frame_q[len-2], frame_q[len-1]};
      exp_pass = (model_crc(len - 4) == ~tl);
    end
    n_pay = (exp_pass && len > 4) ? len - 4 : 0;
    clear_mon();
    for (int i = 0; i < prefix; i++) drive_byte(8'($urandom), i == 0, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle();
      drive_byte(frame_q[i], i == 0, i == len - 1);
    end
    last_cyc = cyc;
    for (int k = 0; k < inject; k++) drive_byte(8'($urandom), 1'b1, 1'b1);
    idle();
    repeat (len + 12) @(posedge clk);
    #1;
    check_eq({tag, " verdicts"}, v_val.size(), 1);
    if (v_val.size() > 0) begin
      check_eq({tag, " verdict_lat"}, v_cyc[0] - last_cyc, 1);
      check_eq({tag, " verdict"}, v_val[0], exp_pass);
    end
    check_eq({tag, " out_count"}, o_dat.size(), n_pay);
    n_chk = (o_dat.size() < n_pay) ? o_dat.size() : n_pay;
    for (int i = 0; i < n_chk; i++) begin
      check_eq($sformatf("%s byte%0d", tag, i), o_dat[i], frame_q[i]);
      check_eq($sformatf("%s flags%0d", tag, i), {o_first[i], o_last[i]},
               {i == 0, i == n_pay - 1});
      check_eq($sformatf("%s time%0d", tag, i), o_cyc[i] - last_cyc, i + 2);
    end
    check_eq({tag, " drops"}, drops, inject);
  endtask

  initial begin
    rst_n        = 1'b0;
    udp_rx       = 8'h00;
    udp_rx_valid = 1'b0;
    udp_rx_first = 1'b0;
    udp_rx_last  = 1'b0;
    drops        = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset outs", {to_udp, to_udp_valid, to_udp_first, to_udp_last, crc_valid,
                            crc_check, rx_busy_drop}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Known payload 01..08.
    frame_q.delete();
    for (int i = 1; i <= 8; i++) frame_q.push_back(8'(i));
    append_crc();
    run_frame("p01_08", 0, 0, 1'b0);

    frame_q[3] = frame_q[3] ^ 8'h01;
    run_frame("flip", 0, 0, 1'b0);

    build_payload(1);
    run_frame("single", 0, 0, 1'b0);

    build_payload(0);
    append_crc();
    run_frame("crc_only", 0, 0, 1'b0);

    build_payload(66);
    append_crc();
    run_frame("overflow", 0, 0, 1'b0);

    build_payload(8);
    append_crc();
    run_frame("after_ovf", 0, 0, 1'b0);

    build_payload(60);
    append_crc();
    run_frame("full64", 0, 0, 1'b0);

    build_payload(6);
    append_crc();
    run_frame("abort", 5, 0, 1'b0);

    build_payload(10);
    append_crc();
    run_frame("busy_drop", 0, 3, 1'b0);

    // Reset during the third SEND cycle.
    build_payload(10);
    append_crc();
    clear_mon();
    for (int i = 0; i < frame_q.size(); i++) drive_byte(frame_q[i], i == 0, i == frame_q.size() - 1);
    last_cyc = cyc;
    idle();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid outs", {to_udp, to_udp_valid, to_udp_first, to_udp_last, crc_valid,
                              crc_check, rx_busy_drop}, 32'h0);
    check_eq("rst_mid verdicts", v_val.size(), 1);
    check_eq("rst_mid out_count", o_dat.size(), 2);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    build_payload(7);
    append_crc();
    run_frame("post_rst", 0, 0, 1'b0);

    // Random frames, some corrupted, some oversize, some with idle gaps and busy drops.
    for (int t = 0; t < 24; t++) begin
      int  n, inj, pos;
      bit  bad;
      n   = $urandom_range(0, 62);
      bad = ($urandom_range(0, 3) == 0);
      build_payload(n);
      append_crc();
      if (bad) begin
        pos          = $urandom_range(0, frame_q.size() - 1);
        frame_q[pos] = frame_q[pos] ^ (8'h01 << $urandom_range(0, 7));
      end
      inj = 0;
      if (!bad && n >= 3 && frame_q.size() <= MaxBytes) inj = $urandom_range(0, 2);
      run_frame($sformatf("rnd%0d", t), ($urandom_range(0, 4) == 0) ? 3 : 0, inj,
                1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
